return_addr_stack: RTL and testbench
====================================

Name: return_addr_stack

Overview:
- Consumer end of the link-address path. Link addresses (PC+4 of jal/jalr calls) are pushed here; return jalr in IF pops them to predict the return target.
- Circular LIFO with speculative pointer, overflow wrap, underflow detection, and flush-time pointer restore for branch/jump mispredict recovery.
- Sits beside the IF-stage next-PC mux. The top entry feeds the return-target candidate.

Parameters:
DEPTH, 8, number of entries; must be a power of 2, at least 2
AW, 32, address width
PW, $clog2(DEPTH), pointer width (derived; not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
push  input  1  call detected; push push_addr
push_addr  input  AW  link address (PC+4) to push
pop  input  1  return detected; pop top entry
flush  input  1  mispredict recovery; restore pointer state
flush_ptr  input  PW  pointer checkpoint to restore
flush_cnt  input  PW+1  count checkpoint to restore
top_addr  output  AW  predicted return address (entry at ptr)
top_valid  output  1  count != 0
ptr  output  PW  current top-of-stack index; checkpointed per instruction by the pipeline
count  output  PW+1  valid entries, 0..DEPTH
underflow  output  1  registered one-cycle pulse: pop attempted with count==0

Behaviour:
- Reset, asynchronous, while rst_n==0:
  - ptr=0, count=0, underflow=0.
  - All entries cleared to 0, so top_addr=0 and top_valid=0.
  - Reset asserted mid-operation discards everything immediately.
- Storage and outputs:
  - Storage is mem[0..DEPTH-1].
  - top_addr = mem[ptr], combinational from registered state.
  - top_valid = (count != 0).
- Priority per cycle: flush > push&pop > push > pop > idle.
- flush:
  - Next ptr = flush_ptr, next count = flush_cnt.
  - Entries are not modified. push and pop are ignored that cycle.
  - underflow = 0 next cycle.
  - flush_cnt > DEPTH is illegal; the result is undefined, and the bench asserts it never occurs.
- push only:
  - ptr <= ptr+1, wrapping modulo DEPTH.
  - mem[ptr+1] <= push_addr.
  - count <= min(count+1, DEPTH).
  - Overflow (count==DEPTH) silently overwrites the oldest entry; count stays DEPTH.
- pop only, count>0:
  - ptr <= ptr-1, wrapping 0 to DEPTH-1.
  - count <= count-1.
  - Entry contents are retained; a later flush may resurrect them.
- pop only, count==0:
  - ptr and count are unchanged; underflow <= 1 for one cycle.
- push&pop same cycle (jalr that is both a return and a call):
  - count>0: mem[ptr] <= push_addr; ptr and count unchanged.
  - count==0: behaves as push only; no underflow.
- underflow deasserts the cycle after any non-underflowing cycle.
- Latency:
  - Push/pop effects are visible on top_addr, top_valid, ptr and count one cycle after the sampling edge.
  - flush restore is visible the next cycle.
- All pointer arithmetic is PW bits with natural wrap. count arithmetic is PW+1 bits with saturation at DEPTH and floor at 0.

Optional Feature:
- Macro: RAS_BYPASS_EN
- Defined: write-before-read bypass. While push=1 and flush=0, top_addr = push_addr combinationally and top_valid = 1 in the same cycle. A back-to-back call/return therefore predicts correctly with zero bubble.
- Undefined: top_addr and top_valid depend only on registered state, per Behaviour; no input-to-output combinational path.
- Registered state evolution is identical in both builds.

Test Plan:
- Reset: rst_n=0 mid-run after 3 pushes -> immediately ptr=0, count=0, top_valid=0, top_addr=0x0; stays cleared after release.
- Basic LIFO: push 0x100, 0x200, 0x300 on consecutive cycles -> count=3, top_addr=0x300. Then pop -> next cycle top_addr=0x200, count=2, ptr=2.
- Overflow/underflow (DEPTH=8): push 0x04..0x24 step 4 (9 pushes) -> count=8, top_addr=0x24. 8 pops yield tops 0x20, 0x1C, ..., 0x08, then count=0. 9th pop -> underflow=1 for exactly one cycle, ptr unchanged.
- Simultaneous: state top_addr=0x200, count=2; push=1, pop=1, push_addr=0x500 -> top_addr=0x500, count=2, ptr unchanged. Same stimulus at count=0 -> count=1, top_addr=0x500, underflow=0.
- Recovery: record ptr=2, count=2 (top 0x200); push 0xA00, pop twice, push 0xB00; flush with flush_ptr=2, flush_cnt=2 -> next cycle top_addr=0x200, count=2. A flush asserted with push in the same cycle ignores the push.
- Bypass: with RAS_BYPASS_EN, push 0xC00 -> top_addr=0xC00 in the same cycle. Without it, top_addr shows 0xC00 only after the edge. Registered state matches in both builds.

Source files
------------

// File: rtl/return_addr_stack.sv
// Return address stack: circular LIFO of link addresses with
// checkpoint restore on flush. Optional bypass via RAS_BYPASS_EN.
module return_addr_stack #(
  parameter  int DEPTH = 8,
  parameter  int AW    = 32,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic          pop,
  input  logic          flush,
  input  logic [PW-1:0] flush_ptr,
  input  logic [PW:0]   flush_cnt,
  output logic [AW-1:0] top_addr,
  output logic          top_valid,
  output logic [PW-1:0] ptr,
  output logic [PW:0]   count,
  output logic          underflow
);

  localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

  logic [AW-1:0] mem [DEPTH];

  logic          empty;
  logic          full;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;
  logic          do_flush;
  logic          do_swap;
  logic          do_push;
  logic          do_pop;
  logic          do_uf;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign ptr_inc = ptr + PW'(1);
  assign ptr_dec = ptr - PW'(1);

  // one-hot operation select, flush dominates, swap needs a live top
  assign do_flush = flush;
  assign do_swap  = !flush && push && pop && !empty;
  assign do_push  = !flush && push && !(pop && !empty);
  assign do_pop   = !flush && pop && !push && !empty;
  assign do_uf    = !flush && pop && !push && empty;

  // pointer, count, underflow and storage update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      count     <= '0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      underflow <= do_uf;
      unique case (1'b1)
        do_flush: begin
          ptr   <= flush_ptr;
          count <= flush_cnt;
        end
        do_swap: begin
          mem[ptr] <= push_addr;
        end
        do_push: begin
          ptr          <= ptr_inc;
          mem[ptr_inc] <= push_addr;
          if (!full)
            count <= count + 1'b1;
        end
        do_pop: begin
          ptr   <= ptr_dec;
          count <= count - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef RAS_BYPASS_EN
  // forward an in-flight push straight to the prediction
  always_comb begin
    top_addr  = mem[ptr];
    top_valid = !empty;
    if (push && !flush) begin
      top_addr  = push_addr;
      top_valid = 1'b1;
    end
  end
`else
  // prediction from registered state only
  always_comb begin
    top_addr  = mem[ptr];
    top_valid = !empty;
  end
`endif

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: vector table plus
// reset, overflow/underflow and bypass sequences through a scoreboard.
module tb_return_addr_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int PW    = 3;

  logic          clk;
  logic          rst_n;
  logic          push;
  logic [AW-1:0] push_addr;
  logic          pop;
  logic          flush;
  logic [PW-1:0] flush_ptr;
  logic [PW:0]   flush_cnt;
  logic [AW-1:0] top_addr;
  logic          top_valid;
  logic [PW-1:0] ptr;
  logic [PW:0]   count;
  logic          underflow;

  return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .flush     (flush),
    .flush_ptr (flush_ptr),
    .flush_cnt (flush_cnt),
    .top_addr  (top_addr),
    .top_valid (top_valid),
    .ptr       (ptr),
    .count     (count),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic [AW-1:0] addr;
    logic          pop;
    logic          flush;
    logic [PW-1:0] fptr;
    logic [PW:0]   fcnt;
    logic [AW-1:0] e_top;
    logic          e_valid;
    logic [PW-1:0] e_ptr;
    logic [PW:0]   e_cnt;
    logic          e_uf;
  } vec_t;

  vec_t vecs [18];
  vec_t exp_q [$];

  int checks = 0;
  int errors = 0;

  always @(posedge clk)
    if (rst_n && flush)
      assert (flush_cnt <= DEPTH)
      else $error("illegal flush_cnt %0d", flush_cnt);

  task automatic chk(input string name, input logic [AW-1:0] act,
                     input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pu, input logic [AW-1:0] a,
                              input logic po, input logic fl,
                              input logic [PW-1:0] fp,
                              input logic [PW:0] fc,
                              input logic [AW-1:0] t, input logic v,
                              input logic [PW-1:0] p,
                              input logic [PW:0] c, input logic u);
    vec_t r;
    r.push = pu; r.addr = a; r.pop = po; r.flush = fl;
    r.fptr = fp; r.fcnt = fc;
    r.e_top = t; r.e_valid = v; r.e_ptr = p; r.e_cnt = c; r.e_uf = u;
    return r;
  endfunction

  task automatic idle_in();
    push = 0; push_addr = '0; pop = 0; flush = 0;
    flush_ptr = '0; flush_cnt = '0;
  endtask

  task automatic check_out(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".top"},   top_addr,         e.e_top);
    chk({tag, ".valid"}, AW'(top_valid),   AW'(e.e_valid));
    chk({tag, ".ptr"},   AW'(ptr),         AW'(e.e_ptr));
    chk({tag, ".cnt"},   AW'(count),       AW'(e.e_cnt));
    chk({tag, ".uf"},    AW'(underflow),   AW'(e.e_uf));
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    push = v.push; push_addr = v.addr; pop = v.pop;
    flush = v.flush; flush_ptr = v.fptr; flush_cnt = v.fcnt;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic do_push(input logic [AW-1:0] a, input logic [AW-1:0] t,
                         input logic [PW-1:0] p, input logic [PW:0] c,
                         input string tag);
    step(mk(1, a, 0, 0, 0, 0, t, 1, p, c, 0), tag);
  endtask

  initial begin
    logic [AW-1:0] t;
    logic [PW:0]   c;
    idle_in();
    rst_n = 0;
    #12;
    chk("rst.ptr", AW'(ptr), '0);
    chk("rst.cnt", AW'(count), '0);
    chk("rst.valid", AW'(top_valid), '0);
    chk("rst.top", top_addr, '0);
    @(negedge clk);
    rst_n = 1;

    // push,addr,pop,flush,fptr,fcnt | top,valid,ptr,cnt,uf
    vecs[0]  = mk(1, 32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 1, 0);
    vecs[1]  = mk(1, 32'h200, 0, 0, 0, 0, 32'h200, 1, 2, 2, 0);
    vecs[2]  = mk(1, 32'h300, 0, 0, 0, 0, 32'h300, 1, 3, 3, 0);
    vecs[3]  = mk(0, 0,       1, 0, 0, 0, 32'h200, 1, 2, 2, 0);
    vecs[4]  = mk(1, 32'hA00, 0, 0, 0, 0, 32'hA00, 1, 3, 3, 0);
    vecs[5]  = mk(0, 0,       1, 0, 0, 0, 32'h200, 1, 2, 2, 0);
    vecs[6]  = mk(0, 0,       1, 0, 0, 0, 32'h100, 1, 1, 1, 0);
    vecs[7]  = mk(1, 32'hB00, 0, 1, 2, 2, 32'h200, 1, 2, 2, 0);
    vecs[8]  = mk(0, 0,       0, 1, 3, 3, 32'hA00, 1, 3, 3, 0);
    vecs[9]  = mk(0, 0,       1, 0, 0, 0, 32'h200, 1, 2, 2, 0);
    vecs[10] = mk(1, 32'h500, 1, 0, 0, 0, 32'h500, 1, 2, 2, 0);
    vecs[11] = mk(0, 0,       1, 0, 0, 0, 32'h100, 1, 1, 1, 0);
    vecs[12] = mk(0, 0,       1, 0, 0, 0, 32'h0,   0, 0, 0, 0);
    vecs[13] = mk(0, 0,       1, 0, 0, 0, 32'h0,   0, 0, 0, 1);
    vecs[14] = mk(0, 0,       0, 0, 0, 0, 32'h0,   0, 0, 0, 0);
    vecs[15] = mk(1, 32'h500, 1, 0, 0, 0, 32'h500, 1, 1, 1, 0);
    vecs[16] = mk(0, 0,       1, 0, 0, 0, 32'h0,   0, 0, 0, 0);
    vecs[17] = mk(0, 0,       1, 1, 2, 2, 32'h500, 1, 2, 2, 0);

    for (int i = 0; i < 18; i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // same-cycle view of a push: bypass forwards, otherwise old top
    @(negedge clk);
    idle_in();
    push = 1; push_addr = 32'hC00;
    #1;
`ifdef RAS_BYPASS_EN
    chk("byp.top", top_addr, 32'hC00);
    chk("byp.valid", AW'(top_valid), 1);
`else
    chk("byp.top", top_addr, 32'h500);
    chk("byp.valid", AW'(top_valid), 1);
`endif
    exp_q.push_back(mk(1, 32'hC00, 0, 0, 0, 0, 32'hC00, 1, 3, 3, 0));
    @(posedge clk);
    #1;
    check_out("byp.after");

    // reset mid-run discards state immediately
    @(negedge clk);
    idle_in();
    do_push(32'h11, 32'h11, 4, 4, "pre0");
    do_push(32'h22, 32'h22, 5, 5, "pre1");
    do_push(32'h33, 32'h33, 6, 6, "pre2");
    @(negedge clk);
    idle_in();
    rst_n = 0;
    #1;
    chk("mrst.ptr", AW'(ptr), '0);
    chk("mrst.cnt", AW'(count), '0);
    chk("mrst.valid", AW'(top_valid), '0);
    chk("mrst.top", top_addr, '0);
    @(negedge clk);
    rst_n = 1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mrst.hold");

    // overflow: 9 pushes, oldest entry overwritten
    for (int i = 1; i <= 9; i++) begin
      t = AW'(4 * i);
      c = (i > DEPTH) ? (PW+1)'(DEPTH) : (PW+1)'(i);
      do_push(t, t, PW'(i), c, $sformatf("ovf%0d", i));
    end

    // drain: tops walk down, final slot holds the overwritten value
    for (int k = 1; k <= 8; k++) begin
      t = (k == 8) ? 32'h24 : AW'(32'h24 - 4 * k);
      step(mk(0, 0, 1, 0, 0, 0, t, (k < 8), PW'(9 - k),
              (PW+1)'(8 - k), 0), $sformatf("drn%0d", k));
    end
    step(mk(0, 0, 1, 0, 0, 0, 32'h24, 0, 1, 0, 1), "unf");
    step(mk(0, 0, 0, 0, 0, 0, 32'h24, 0, 1, 0, 0), "unf.clr");

    // underflow cleared by a flush-only cycle
    step(mk(0, 0, 1, 0, 0, 0, 32'h24, 0, 1, 0, 1), "unf2");
    step(mk(0, 0, 1, 1, 0, 8, 32'h20, 1, 0, 8, 0), "unf2.fl");

    @(negedge clk);
    idle_in();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
